// File: rtl/uart_frame_parser_pkg.sv
// Shared UART definitions: frame header, parser state encoding and bit-period derivation.
package uart_frame_parser_pkg;

  localparam logic [7:0] FRM_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_OUT
  } state_e;

  // Clocks per UART bit; the receiver and transmitter use the same derivation.
  function automatic int unsigned uart_bps(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out signal bundle of the UART frame parser.
interface uart_frame_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_last;
  logic       frm_ready;
  logic       err_len;
  logic       err_chk;
  logic       err_ovr;
  logic       err_tmo;

  // Parser side
  modport slave (
    input  rx_data, rx_valid, frm_ready,
    output frm_data, frm_valid, frm_last, err_len, err_chk, err_ovr, err_tmo
  );

  // Byte source / frame sink side
  modport master (
    output rx_data, rx_valid, frm_ready,
    input  frm_data, frm_valid, frm_last, err_len, err_chk, err_ovr, err_tmo
  );

endinterface

// File: rtl/uart_frame_parser_buf.sv
// Payload store: DEPTH x 8 register file, synchronous write, combinational read.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR/LEN/payload/CHK frames from a UART byte stream and replays payloads on valid/ready.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 65_000_000,
  parameter int unsigned BAUT_RATE     = 115200,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_parser_if.slave   bus
);

  localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam int unsigned TMO_CYC = uart_bps(CLK_FREQ, BAUT_RATE) * 10 * TIMEOUT_BYTES;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TMO_CYC == 0) begin : g_bad_cfg
    $error("uart_frame_parser: invalid MAX_LEN or timeout configuration");
  end

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       err_len_q, err_len_d;
  logic       err_chk_q, err_chk_d;
  logic       err_ovr_q, err_ovr_d;
  logic       buf_we;
  logic [7:0] rd_byte;
  logic [7:0] chk_sum;
  logic       out_last;
  logic       tmo_hit;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_cnt_q[AW-1:0]),
    .wdata_i (bus.rx_data),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (rd_byte)
  );

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] gap_q, gap_d;
  logic          err_tmo_q;
  logic          counting;

  assign counting = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // A byte landing on the terminal count wins over the timeout.
  assign tmo_hit  = counting && !bus.rx_valid && (gap_q == TW'(TMO_CYC - 1));

  always_comb begin
    gap_d = gap_q + TW'(1);
    if (bus.rx_valid || !counting) gap_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      err_tmo_q <= tmo_hit;
    end
  end

  assign bus.err_tmo = err_tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.err_tmo = 1'b0;
`endif

  assign chk_sum  = sum_q + bus.rx_data;
  assign out_last = (rd_cnt_q == len_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    buf_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && bus.rx_data == FRM_HDR) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (bus.rx_valid) begin
          len_d    = bus.rx_data;
          sum_d    = bus.rx_data;
          wr_cnt_d = '0;
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          buf_we = 1'b1;
          sum_d  = chk_sum;
          // Counter parks at zero rather than stepping past the last slot.
          if (wr_cnt_q == len_q - 8'd1) begin
            wr_cnt_d = '0;
            state_d  = ST_CHK;
          end else begin
            wr_cnt_d = wr_cnt_q + 8'd1;
          end
        end
      end
      ST_CHK: begin
        if (bus.rx_valid) begin
          if (chk_sum == 8'd0) begin
            rd_cnt_d = '0;
            state_d  = ST_OUT;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        if (bus.rx_valid) err_ovr_d = 1'b1;
        if (bus.frm_ready) begin
          if (out_last) begin
            rd_cnt_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign bus.frm_valid = (state_q == ST_OUT);
  assign bus.frm_data  = bus.frm_valid ? rd_byte : '0;
  assign bus.frm_last  = bus.frm_valid && out_last;
  assign bus.err_len   = err_len_q;
  assign bus.err_chk   = err_chk_q;
  assign bus.err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed plan vectors plus randomized frames.
module tb_uart_frame_parser;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = (65_000_000 / 115200) * 10 * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_parser_if bus();

  uart_frame_parser #(
    .CLK_FREQ      (65_000_000),
    .BAUT_RATE     (115200),
    .MAX_LEN       (MAXL),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [8:0]  exp_q[$];   // {last, data}
  logic [3:0]  err_q[$];   // one-hot {tmo, ovr, chk, len}
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Reference model: frame outcome follows directly from LEN range and byte sum.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$],
                            input bit corrupt, input int maxgap);
    int unsigned sum;
    logic [7:0]  chk;
    drive(8'hA5);
    idle($urandom_range(0, maxgap));
    if (len == 0 || len > MAXL) begin
      err_q.push_back(4'b0001);
      drive(len);
      return;
    end
    drive(len);
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      idle($urandom_range(0, maxgap));
      drive(pay[i]);
      sum += pay[i];
    end
    chk = 8'((256 - (sum % 256)) % 256);
    if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
    if (corrupt) err_q.push_back(4'b0010);
    else for (int i = 0; i < int'(len); i++) exp_q.push_back({(i == int'(len) - 1), pay[i]});
    idle($urandom_range(0, maxgap));
    drive(chk);
  endtask

  task automatic wait_drain;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_q.size() == 0 && err_q.size() == 0 && !bus.frm_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("drain", done, 1'b1);
    exp_q.delete();
    err_q.delete();
    idle(2);
  endtask

  initial begin
    bus.frm_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.frm_ready = 1'b1;
        1:       bus.frm_ready = 1'($urandom_range(0, 1));
        default: bus.frm_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations on every handshake and every error pulse.
  initial begin
    bit         hold = 1'b0;
    logic [8:0] held = '0;
    logic [3:0] errs;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_valid", bus.frm_valid, 1'b1);
        if (bus.frm_valid) check("hold_stable", {bus.frm_last, bus.frm_data}, held);
      end
      if (bus.frm_valid && bus.frm_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {bus.frm_last, bus.frm_data}, 9'h1ff ^ {bus.frm_last, bus.frm_data});
        else check("frm_byte", {bus.frm_last, bus.frm_data}, exp_q.pop_front());
      end
      hold = bus.frm_valid && !bus.frm_ready;
      held = {bus.frm_last, bus.frm_data};
      errs = {bus.err_tmo, bus.err_ovr, bus.err_chk, bus.err_len};
      if (errs != 4'b0) begin
        if (err_q.size() == 0) check("unexpected_err", errs, 4'b0);
        else check("err_pulse", errs, err_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] len;
    int         kind;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rst = 1'b1;
    idle(4);
    @(negedge clk);
    check("rst_out", {bus.frm_valid, bus.frm_last, bus.frm_data,
                      bus.err_len, bus.err_chk, bus.err_ovr, bus.err_tmo}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Plan vector: A5 03 11 22 33 97 streamed back-to-back
    rdy_mode = 0;
    drive(8'hA5); drive(8'h03); drive(8'h11); drive(8'h22); drive(8'h33);
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
    drive(8'h97);
    check("lat_valid", bus.frm_valid, 1'b1);
    check("lat_data", bus.frm_data, 8'h11);
    idle(2);
    check("last_data", {bus.frm_last, bus.frm_data}, {1'b1, 8'h33});
    idle(1);
    check("stream_end", bus.frm_valid, 1'b0);
    wait_drain();

    // Bad checksum, then a one-byte good frame
    err_q.push_back(4'b0010);
    drive(8'hA5); drive(8'h03); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h96);
    check("chk_novalid", bus.frm_valid, 1'b0);
    idle(3);
    check("chk_novalid2", bus.frm_valid, 1'b0);
    exp_q.push_back({1'b1, 8'hFF});
    drive(8'hA5); drive(8'h01); drive(8'hFF); drive(8'h00);
    wait_drain();

    // Length errors: 17 and 0, then a good frame
    err_q.push_back(4'b0001);
    drive(8'hA5); drive(8'h11);
    wait_drain();
    err_q.push_back(4'b0001);
    drive(8'hA5); drive(8'h00);
    wait_drain();
    pay = {8'h5C, 8'hA5};
    send_frame(8'd2, pay, 1'b0, 0);
    wait_drain();

    // Mid-stream stall of 5 cycles
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'd4, pay, 1'b0, 0);
    idle(1);
    rdy_mode = 2;
    idle(5);
    rdy_mode = 0;
    wait_drain();

    // Overrun while three bytes are pending
    rdy_mode = 2;
    pay = {8'hAA, 8'hBB, 8'hCC};
    send_frame(8'd3, pay, 1'b0, 0);
    err_q.push_back(4'b0100);
    drive(8'h5A);
    idle(2);
    rdy_mode = 0;
    wait_drain();
    pay = {8'h77};
    send_frame(8'd1, pay, 1'b0, 0);
    wait_drain();

    // Reset mid-frame aborts silently
    drive(8'hA5); drive(8'h03); drive(8'h11);
    rst = 1'b1; idle(1); rst = 1'b0;
    pay = {8'h42, 8'h43};
    send_frame(8'd2, pay, 1'b0, 0);
    wait_drain();

`ifdef UART_PARSER_TIMEOUT_EN
    err_q.push_back(4'b1000);
    drive(8'hA5); drive(8'h03); drive(8'h11);
    idle(TMO + 5);
    drive(8'h22); drive(8'h33);
    idle(5);
    wait_drain();
    drive(8'hA5); drive(8'h03); drive(8'h11);
    idle(TMO - 1);
    drive(8'h22);
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
    drive(8'h33); drive(8'h97);
    wait_drain();
`endif

    // Randomized frames, junk and errors with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      pay.delete();
      if (kind <= 5) begin
        len = 8'($urandom_range(1, MAXL));
        for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom_range(0, 255)));
        send_frame(len, pay, kind == 5, 2);
      end else if (kind <= 7) begin
        len = (kind == 6) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
        send_frame(len, pay, 1'b0, 2);
      end else begin
        len = 8'($urandom_range(0, 255));
        if (len == 8'hA5) len = 8'h5A;
        drive(len);
      end
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
